unary_mac_engine: RTL and testbench

Multi-lane temporal-unary dot-product engine. Computes sum over lanes of a_j*b_j, optionally added to the previous result.
- Operand a is expanded in time: a lane is active while the counter is below |a_j|. Each active lane contributes its binary b_j every cycle.
- Unlike the previous-generation unary/binary MAC, it adds signed (sign-magnitude) mode, accumulate-into-previous mode, and early termination at max|a_j|.
- Uses valid/ready handshakes on both sides. Sits between the operand scheduler and the result writeback in the MAC array.

---
 rtl/unary_mac_pkg.sv | 28 ++
 rtl/unary_mac_lane.sv | 34 +++
 rtl/unary_mac_engine.sv | 108 ++++++++++
 tb/tb_unary_mac_engine.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/unary_mac_pkg.sv
// Shared types and sign-magnitude helpers for the temporal-unary MAC engine.
// The helpers work on values extended to MAX_SIZE bits, so a lane of any SIZE up to MAX_SIZE-1 can use them.
package unary_mac_pkg;

  localparam int MAX_SIZE = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // The caller sign-extends the value in signed mode and zero-extends it otherwise.
  // The magnitude of -2^(SIZE-1) therefore comes out as 2^(SIZE-1).
  function automatic logic [MAX_SIZE:0] mag(input logic [MAX_SIZE-1:0] value,
                                            input logic signed_mode);
    logic [MAX_SIZE:0] ext;
    ext = {signed_mode & value[MAX_SIZE-1], value};
    return (signed_mode && ext[MAX_SIZE]) ? -ext : ext;
  endfunction

  function automatic logic neg(input logic [MAX_SIZE-1:0] a,
                               input logic [MAX_SIZE-1:0] b,
                               input logic signed_mode);
    return signed_mode && (($signed(a) < 0) != ($signed(b) < 0));
  endfunction

endpackage

// File: rtl/unary_mac_lane.sv
// One a_j*b_j lane. Each cycle the lane adds +/-|b_j| while the counter is below |a_j|.
module unary_mac_lane
  import unary_mac_pkg::*;
#(
  parameter int SIZE  = 8,
  parameter int ACC_W = 2*SIZE+8
) (
  input  logic [SIZE-1:0]  a,
  input  logic [SIZE-1:0]  b,
  input  logic             signed_mode,
  input  logic [SIZE:0]    counter,
  output logic [ACC_W-1:0] contrib,
  output logic [SIZE:0]    mag_a
);

  logic [MAX_SIZE-1:0] a_ext;
  logic [MAX_SIZE-1:0] b_ext;
  logic [MAX_SIZE:0]   mag_a_full;
  logic [MAX_SIZE:0]   mag_b_full;
  logic [ACC_W-1:0]    term;

  always_comb begin
    a_ext      = {{(MAX_SIZE-SIZE){signed_mode & a[SIZE-1]}}, a};
    b_ext      = {{(MAX_SIZE-SIZE){signed_mode & b[SIZE-1]}}, b};
    mag_a_full = mag(a_ext, signed_mode);
    mag_b_full = mag(b_ext, signed_mode);
    mag_a      = (SIZE+1)'(mag_a_full);
    term       = ACC_W'(mag_b_full);
    contrib    = '0;
    if (counter < mag_a)
      contrib = neg(a_ext, b_ext, signed_mode) ? -term : term;
  end

endmodule

// File: rtl/unary_mac_engine.sv
// Multi-lane temporal-unary dot-product engine with valid/ready handshakes on both sides.
// state | meaning: IDLE = waiting for operands, RUN = unary expansion of a, DONE = result held.
module unary_mac_engine
  import unary_mac_pkg::*;
#(
  parameter int SIZE  = 8,
  parameter int LANES = 4,
  parameter int ACC_W = 2*SIZE+8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES*SIZE-1:0] a,
  input  logic [LANES*SIZE-1:0] b,
  input  logic                  signed_mode,
  input  logic                  accumulate,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_W-1:0]      out,
  output logic                  busy
);

  state_t                      state;
  logic [LANES*SIZE-1:0]       a_q;
  logic [LANES*SIZE-1:0]       b_q;
  logic                        mode_q;
  logic [SIZE:0]               counter;
  logic [SIZE:0]               max_a;
  logic [SIZE:0]               run_len;
  logic [ACC_W-1:0]            acc;
  logic [ACC_W-1:0]            lane_sum;
  logic [LANES-1:0][ACC_W-1:0] contrib;
  logic [LANES-1:0][SIZE:0]    mag_a;

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    unary_mac_lane #(.SIZE(SIZE), .ACC_W(ACC_W)) u_lane (
      .a           (a_q[j*SIZE +: SIZE]),
      .b           (b_q[j*SIZE +: SIZE]),
      .signed_mode (mode_q),
      .counter     (counter),
      .contrib     (contrib[j]),
      .mag_a       (mag_a[j])
    );
  end

  always_comb begin
    max_a    = '0;
    lane_sum = '0;
    for (int j = 0; j < LANES; j++) begin
      if (mag_a[j] > max_a)
        max_a = mag_a[j];
      lane_sum = lane_sum + contrib[j];
    end
    run_len = (max_a == '0) ? (SIZE+1)'(1) : max_a;
  end

  // When the counter reaches run_len, every lane is idle and the accumulator already holds the final sum.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      mode_q    <= 1'b0;
      counter   <= '0;
      acc       <= '0;
      out       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q      <= a;
            b_q      <= b;
            mode_q   <= signed_mode;
            counter  <= '0;
            acc      <= accumulate ? acc : '0;
            state    <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          if (counter == run_len) begin
            out       <= acc;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            acc     <= acc + lane_sum;
            counter <= counter + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_unary_mac_engine.sv
// Directed and random checks of unary_mac_engine (SIZE=4, LANES=2) against an integer dot-product model.
module tb_unary_mac_engine;

  localparam int SIZE  = 4;
  localparam int LANES = 2;
  localparam int ACC_W = 16;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [7:0]        a = '0;
  logic [7:0]        b = '0;
  logic              signed_mode = 1'b0;
  logic              accumulate = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [ACC_W-1:0]  out;
  logic              busy;

  int checks = 0;
  int errors = 0;
  logic [ACC_W-1:0] model_out = '0;
  int exp_lat = 0;

  unary_mac_engine #(.SIZE(SIZE), .LANES(LANES), .ACC_W(ACC_W)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .signed_mode (signed_mode),
    .accumulate  (accumulate),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out         (out),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic int val(input logic [3:0] v, input bit sm);
    return sm ? int'($signed(v)) : int'(v);
  endfunction

  function automatic int absv(input int x);
    return (x < 0) ? -x : x;
  endfunction

  // Drives one operand set and updates the model with the result and the latency it expects.
  task automatic start_op(input logic [3:0] a0, input logic [3:0] a1,
                          input logic [3:0] b0, input logic [3:0] b1,
                          input bit sm, input bit ac);
    int n;
    int sum;
    int mx;
    n = 0;
    while (!in_ready && n < 400) begin
      @(posedge clk); #1; n++;
    end
    check("in_ready_before_accept", 32'(in_ready), 32'd1);
    a = {a1, a0}; b = {b1, b0}; signed_mode = sm; accumulate = ac; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 8'($urandom); b = 8'($urandom); signed_mode = 1'($urandom); accumulate = 1'($urandom);
    sum = val(a0, sm) * val(b0, sm) + val(a1, sm) * val(b1, sm);
    model_out = ac ? ACC_W'(int'(model_out) + sum) : ACC_W'(sum);
    mx = (absv(val(a0, sm)) > absv(val(a1, sm))) ? absv(val(a0, sm)) : absv(val(a1, sm));
    exp_lat = ((mx == 0) ? 1 : mx) + 1;
    check("in_ready_low_after_accept", 32'(in_ready), 32'd0);
  endtask

  task automatic wait_result(input string tag);
    int n;
    n = 0;
    while (!out_valid && n < 400) begin
      check({tag, "_busy"}, 32'(busy), 32'd1);
      @(posedge clk); #1; n++;
    end
    check({tag, "_latency"}, 32'(n), 32'(exp_lat));
    check({tag, "_out"}, 32'(out), 32'(model_out));
    check({tag, "_busy_done"}, 32'(busy), 32'd1);
  endtask

  task automatic handoff(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_in_ready_after"}, 32'(in_ready), 32'd1);
    check({tag, "_out_valid_after"}, 32'(out_valid), 32'd0);
    check({tag, "_out_held"}, 32'(out), 32'(model_out));
  endtask

  initial begin
    #12;
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_out", 32'(out), 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    start_op(4'd3, 4'd5, 4'd7, 4'd2, 1'b0, 1'b0);
    wait_result("unsigned");
    check("unsigned_value", 32'(out), 32'd31);
    handoff("unsigned");

    start_op(4'd2, 4'd0, 4'd4, 4'd9, 1'b0, 1'b1);
    wait_result("accum_chain");
    check("accum_chain_value", 32'(out), 32'd39);
    handoff("accum_chain");

    start_op(4'd1, 4'd1, 4'd1, 4'd1, 1'b0, 1'b0);
    wait_result("accum_clear");
    handoff("accum_clear");

    start_op(4'hD, 4'h8, 4'h5, 4'h7, 1'b1, 1'b0);
    wait_result("signed");
    check("signed_value", 32'(out), 32'(16'hFFB9));
    handoff("signed");

    start_op(4'd0, 4'd0, 4'd15, 4'd15, 1'b0, 1'b0);
    wait_result("zero_a");
    handoff("zero_a");

    start_op(4'h8, 4'h8, 4'h8, 4'h8, 1'b1, 1'b1);
    wait_result("signed_min");
    handoff("signed_min");

    start_op(4'd2, 4'd1, 4'd6, 4'd3, 1'b0, 1'b0);
    wait_result("backpressure");
    for (int i = 0; i < 5; i++) begin
      in_valid = ~in_valid;
      a = 8'($urandom); b = 8'($urandom); accumulate = 1'($urandom);
      @(posedge clk); #1;
      check("bp_out_stable", 32'(out), 32'(model_out));
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    handoff("backpressure");
    @(posedge clk); #1;
    check("bp_no_capture_busy", 32'(busy), 32'd0);

    start_op(4'd7, 4'd7, 4'd3, 4'd3, 1'b0, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2 reset_n = 1'b0;
    #1;
    model_out = '0;
    check("rst_out", 32'(out), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    #2 reset_n = 1'b1;
    @(posedge clk); #1;
    start_op(4'd3, 4'd2, 4'd5, 4'd4, 1'b0, 1'b1);
    wait_result("after_reset");
    check("after_reset_value", 32'(out), 32'd23);
    handoff("after_reset");

    for (int k = 0; k < 40; k++) begin
      start_op(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
               1'($urandom), 1'($urandom));
      wait_result("random");
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
        check("random_hold", 32'(out), 32'(model_out));
      end
      handoff("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
